// File: rtl/eprisc_io_pkg.sv
// ---------------------------------------------------------------------------
// eprisc_io_pkg
// Shared definitions for epRISC I/O-bus peripherals: register addresses,
// CONTROL/STATUS bit positions, UART state encodings and a word-mask helper.
// ---------------------------------------------------------------------------
package eprisc_io_pkg;

  // Register map
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_DATA = 2'd2;
  localparam logic [1:0] ADDR_DIV  = 2'd3;

  // CONTROL bit indices
  localparam int CTRL_TXEN    = 0;
  localparam int CTRL_RXEN    = 1;
  localparam int CTRL_PEN     = 2;
  localparam int CTRL_PODD    = 3;
  localparam int CTRL_STOP2   = 4;
  localparam int CTRL_WLEN_LO = 5;
  localparam int CTRL_WLEN_HI = 6;
  localparam int CTRL_RXIE    = 7;
  localparam int CTRL_TXIE    = 8;
  localparam int CTRL_W       = 9;

  // STATUS bit indices
  localparam int STAT_TXFULL  = 0;
  localparam int STAT_TXEMPTY = 1;
  localparam int STAT_TXBUSY  = 2;
  localparam int STAT_RXAVAIL = 3;
  localparam int STAT_RXFULL  = 4;
  localparam int STAT_OVERRUN = 5;
  localparam int STAT_PERR    = 6;
  localparam int STAT_FERR    = 7;
  localparam int STAT_CNT_LO  = 8;
  localparam int STAT_CNT_HI  = 15;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Mask of the active data bits for a WLEN code (0=5 .. 3=8 bits).
  function automatic logic [7:0] word_mask(input logic [1:0] wlen);
    return 8'hFF >> (2'd3 - wlen);
  endfunction

endpackage

// File: rtl/eprisc_sync_fifo.sv
// ---------------------------------------------------------------------------
// eprisc_sync_fifo
// Single-clock FIFO with wrap-bit pointers. Head data is combinational and
// reads 0 when empty. A push while full is accepted only if a pop happens in
// the same cycle; a pop while empty is ignored.
// Ports: iSClk/iRst clock and async active-high reset; push/push_data write
// side; pop/head read side; full, empty, count (0..DEPTH) status.
// ---------------------------------------------------------------------------
module eprisc_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   iSClk,
  input  logic                   iRst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps combinational blocks free of latches.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from before the edge, independent of statement order.
  always_ff @(posedge iSClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity
  // and an unreset array maps onto plain RAM/regfile cells.
  always_ff @(posedge iSClk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/eprisc_uart_v2.sv
// ---------------------------------------------------------------------------
// eprisc_uart_v2
// Two-pin RS232 UART on the epRISC 16-bit I/O bus with TX/RX FIFOs,
// programmable baud divider, 5-8 bit words, optional parity, 1/2 stop bits.
// Ports: iSClk clock; iRst async active-high reset; iAddr/iData/iWrite/
// iEnable bus access, oData read data (high-Z when idle); iRX async serial
// in; oTX registered serial out; oInt registered level interrupt.
// ---------------------------------------------------------------------------
module eprisc_uart_v2 import eprisc_io_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic        iSClk,
  input  logic        iRst,
  input  logic [1:0]  iAddr,
  input  logic [15:0] iData,
  output logic [15:0] oData,
  input  logic        iWrite,
  input  logic        iEnable,
  input  logic        iRX,
  output logic        oTX,
  output logic        oInt
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam logic [TCW-1:0] OS_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] OS_MID  = TCW'(OVERSAMPLE / 2 - 1);

  // Bus / register state
  logic              en_q, en_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DIV_W-1:0]  div_q, div_d, div_cnt_q, div_cnt_d;
  logic              overrun_q, overrun_d, perr_q, perr_d, ferr_q, ferr_d;
  logic              int_q, int_d;

  // TX state
  tx_state_e         tx_state_q, tx_state_d;
  logic [TCW-1:0]    tx_tick_q, tx_tick_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              tx_par_q, tx_par_d, tx_q, tx_d;

  // RX state
  logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  rx_state_e         rx_state_q, rx_state_d;
  logic [TCW-1:0]    rx_tick_q, rx_tick_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_par_q, rx_par_d, rx_perr_q, rx_perr_d;

  // FIFO hookup
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;

  // Decoded control fields
  logic       txen, rxen, pen, podd, stop2, rxie, txie;
  logic [1:0] wlen;
  logic [2:0] wlen_last;
  assign txen      = ctrl_q[CTRL_TXEN];
  assign rxen      = ctrl_q[CTRL_RXEN];
  assign pen       = ctrl_q[CTRL_PEN];
  assign podd      = ctrl_q[CTRL_PODD];
  assign stop2     = ctrl_q[CTRL_STOP2];
  assign wlen      = ctrl_q[CTRL_WLEN_HI:CTRL_WLEN_LO];
  assign rxie      = ctrl_q[CTRL_RXIE];
  assign txie      = ctrl_q[CTRL_TXIE];
  assign wlen_last = {1'b0, wlen} + 3'd4;   // index of the last data bit

  // Only the first cycle of an iEnable pulse commits an access.
  logic access, w1c, baud_tick;
  logic set_overrun, set_perr, set_ferr;
  assign access  = iEnable & ~en_q;
  assign w1c     = access & iWrite & (iAddr == ADDR_STAT);
  assign tx_push = access & iWrite & (iAddr == ADDR_DATA);
  assign rx_pop  = access & ~iWrite & (iAddr == ADDR_DATA);

  eprisc_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .iSClk(iSClk), .iRst(iRst), .push(tx_push), .push_data(iData[7:0]),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty),
    .count(tx_count)
  );

  eprisc_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .iSClk(iSClk), .iRst(iRst), .push(rx_push), .push_data(rx_shift_q),
    .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty),
    .count(rx_count)
  );

  // Registers, baud divider, sticky flags, interrupt
  always_comb begin
    en_d      = iEnable;
    ctrl_d    = ctrl_q;
    div_d     = div_q;
    if (access && iWrite && iAddr == ADDR_CTRL) ctrl_d = iData[CTRL_W-1:0];
    if (access && iWrite && iAddr == ADDR_DIV)  div_d  = iData[DIV_W-1:0];

    // >= so that shrinking the divisor mid-count cannot stall the tick.
    baud_tick = (div_cnt_q >= div_q);
    div_cnt_d = baud_tick ? '0 : div_cnt_q + 1'b1;

    // A hardware set in the same cycle as a W1C wins.
    overrun_d = (overrun_q & ~(w1c & iData[STAT_OVERRUN])) | set_overrun;
    perr_d    = (perr_q    & ~(w1c & iData[STAT_PERR]))    | set_perr;
    ferr_d    = (ferr_q    & ~(w1c & iData[STAT_FERR]))    | set_ferr;

    int_d = (rxie & (~rx_empty | overrun_q | perr_q | ferr_q)) |
            (txie & tx_empty & (tx_state_q == TX_IDLE));
  end

  // TX state machine
  logic tx_bit_end, tx_can_start, tx_load;
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_tick_d    = tx_tick_q;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    tx_par_d     = tx_par_q;
    tx_load      = 1'b0;
    tx_can_start = txen & (tx_count != '0);
    tx_bit_end   = baud_tick & (tx_tick_q == OS_LAST);

    if (baud_tick && tx_state_q != TX_IDLE)
      tx_tick_d = tx_bit_end ? '0 : tx_tick_q + 1'b1;

    case (tx_state_q)
      TX_IDLE:   if (baud_tick && tx_can_start) tx_load = 1'b1;
      TX_START:  if (tx_bit_end) begin
                   tx_state_d = TX_DATA;
                   tx_bit_d   = '0;
                 end
      TX_DATA:   if (tx_bit_end) begin
                   if (tx_bit_q == wlen_last) begin
                     tx_state_d = pen ? TX_PARITY : TX_STOP1;
                   end else begin
                     tx_shift_d = tx_shift_q >> 1;
                     tx_bit_d   = tx_bit_q + 1'b1;
                   end
                 end
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP1;
      // A queued byte starts right after the last stop bit, so frames run
      // back-to-back without an idle gap.
      TX_STOP1:  if (tx_bit_end) begin
                   if (stop2)             tx_state_d = TX_STOP2;
                   else if (tx_can_start) tx_load    = 1'b1;
                   else                   tx_state_d = TX_IDLE;
                 end
      TX_STOP2:  if (tx_bit_end) begin
                   if (tx_can_start) tx_load    = 1'b1;
                   else              tx_state_d = TX_IDLE;
                 end
      default:   tx_state_d = TX_IDLE;
    endcase

    if (tx_load) begin
      tx_state_d = TX_START;
      tx_tick_d  = '0;
      tx_shift_d = tx_head;
      tx_par_d   = (^(tx_head & word_mask(wlen))) ^ podd;
    end
    tx_pop = tx_load;

    // Line value follows the next state so oTX stays aligned with the FSM.
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // RX state machine
  logic rx_fall, rx_bit_end, rx_mid;
  always_comb begin
    rx_s1_d     = iRX;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    rx_state_d  = rx_state_q;
    rx_tick_d   = rx_tick_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_par_d    = rx_par_q;
    rx_perr_d   = rx_perr_q;
    rx_push     = 1'b0;
    set_ferr    = 1'b0;
    set_perr    = 1'b0;
    rx_fall     = rx_prev_q & ~rx_s2_q;
    rx_bit_end  = baud_tick & (rx_tick_q == OS_LAST);
    rx_mid      = baud_tick & (rx_tick_q == OS_MID);

    if (baud_tick && rx_state_q != RX_IDLE)
      rx_tick_d = rx_bit_end ? '0 : rx_tick_q + 1'b1;

    case (rx_state_q)
      RX_IDLE:   if (rxen && rx_fall) begin
                   rx_state_d = RX_START;
                   rx_tick_d  = '0;
                   rx_bit_d   = '0;
                   rx_shift_d = '0;
                   rx_par_d   = 1'b0;
                   rx_perr_d  = 1'b0;
                 end
      // Mid-start check; from here every sample lands one full bit later.
      RX_START:  if (rx_mid) begin
                   rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                   rx_tick_d  = '0;
                 end
      RX_DATA:   if (rx_bit_end) begin
                   rx_shift_d[rx_bit_q] = rx_s2_q;
                   rx_par_d             = rx_par_q ^ rx_s2_q;
                   if (rx_bit_q == wlen_last) rx_state_d = pen ? RX_PARITY : RX_STOP;
                   else                       rx_bit_d   = rx_bit_q + 1'b1;
                 end
      RX_PARITY: if (rx_bit_end) begin
                   rx_perr_d  = rx_s2_q ^ rx_par_q ^ podd;
                   rx_state_d = RX_STOP;
                 end
      RX_STOP:   if (rx_bit_end) begin
                   rx_push    = 1'b1;
                   set_ferr   = ~rx_s2_q;
                   set_perr   = rx_perr_q;
                   rx_state_d = RX_IDLE;
                 end
      default:   rx_state_d = RX_IDLE;
    endcase

    if (!rxen) begin
      rx_state_d = RX_IDLE;
      rx_push    = 1'b0;
      set_ferr   = 1'b0;
      set_perr   = 1'b0;
    end
    // Full implies non-empty, so a same-cycle pop always frees a slot.
    set_overrun = rx_push & rx_full & ~rx_pop;
  end

  always_ff @(posedge iSClk or posedge iRst) begin
    if (iRst) begin
      en_q       <= 1'b0;
      ctrl_q     <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      overrun_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      int_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      en_q       <= en_d;
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      overrun_q  <= overrun_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      int_q      <= int_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // Combinational read mux
  logic [15:0] rd_data;
  always_comb begin
    rd_data = '0;
    case (iAddr)
      ADDR_CTRL: rd_data[CTRL_W-1:0] = ctrl_q;
      ADDR_STAT: begin
        rd_data[STAT_TXFULL]  = tx_full;
        rd_data[STAT_TXEMPTY] = tx_empty;
        rd_data[STAT_TXBUSY]  = (tx_state_q != TX_IDLE);
        rd_data[STAT_RXAVAIL] = ~rx_empty;
        rd_data[STAT_RXFULL]  = rx_full;
        rd_data[STAT_OVERRUN] = overrun_q;
        rd_data[STAT_PERR]    = perr_q;
        rd_data[STAT_FERR]    = ferr_q;
        rd_data[STAT_CNT_HI:STAT_CNT_LO] = 8'(rx_count);
      end
      ADDR_DATA: rd_data[7:0]       = rx_head;
      default:   rd_data[DIV_W-1:0] = div_q;
    endcase
  end

  assign oData = iEnable ? rd_data : 16'bz;
  assign oTX   = tx_q;
  assign oInt  = int_q;

endmodule
